sram_port_arbiter: RTL

Two-requester arbiter sharing the single-port-pair on-chip `sram` (13-bit word address, 1-cycle read latency) between the AXI-to-SRAM bridge (port 0) and a second SRAM-style master such as a DMA or debug loader (port 1). It sits between the masters' `ram_*` interfaces and the `sram` instance. It grants at most one access per cycle, round-robin with optional bounded locking, and routes read data back to the requester that issued the read.

---
 rtl/sram_port_arbiter_pkg.sv | 14 +
 rtl/sram_port_arbiter_rr_arb2.sv | 82 ++++++++
 rtl/sram_port_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// Shared constants and types for the two-port SRAM arbiter.
// Width defaults match the system bus; MAX_LOCK bounds how long a locked port can starve the other.
package sram_port_arbiter_pkg;

  localparam int BUS_WIDTH         = 32;
  localparam int DATA_WIDTH        = 32;
  localparam int SRAM_ARB_MAX_LOCK = 4;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

endpackage

// File: rtl/sram_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with bounded priority locking.
// Grant is combinational from req and prio; prio/lock_cnt update on every transfer.
module rr_arb2
  import sram_port_arbiter_pkg::*;
#(
  parameter int MAX_LOCK = SRAM_ARB_MAX_LOCK,
  localparam int CW = $clog2(MAX_LOCK + 1)
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  output logic [1:0] gnt
);

  logic          prio;
  logic          last_win;
  logic [CW-1:0] lock_cnt;
  logic          prio_nxt;
  logic          last_nxt;
  logic [CW-1:0] cnt_nxt;
  logic          win;
  logic          win_lock;
  logic          other_req;
  logic [CW-1:0] cnt_base;

  // grant decode: a lone requester wins, contention goes to prio
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = prio ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  assign win       = gnt[1];
  assign win_lock  = win ? lock[1] : lock[0];
  assign other_req = win ? req[0] : req[1];
  // a streak only continues while the same port keeps winning
  assign cnt_base  = (win == last_win) ? lock_cnt : {CW{1'b0}};

  // pointer and lock-streak update on each transfer
  always_comb begin
    prio_nxt = prio;
    last_nxt = last_win;
    cnt_nxt  = lock_cnt;
    if (|gnt) begin
      last_nxt = win;
      if (!win_lock) begin
        cnt_nxt  = {CW{1'b0}};
        prio_nxt = ~win;
      end else if (!other_req) begin
        cnt_nxt  = cnt_base;
        prio_nxt = win;
      end else if (cnt_base >= CW'(MAX_LOCK - 1)) begin
        cnt_nxt  = {CW{1'b0}};
        prio_nxt = ~win;
      end else begin
        cnt_nxt  = cnt_base + CW'(1);
        prio_nxt = win;
      end
    end else begin
      cnt_nxt = lock_cnt;
    end
  end

  // arbitration state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prio     <= 1'b0;
      last_win <= 1'b0;
      lock_cnt <= {CW{1'b0}};
    end else begin
      prio     <= prio_nxt;
      last_win <= last_nxt;
      lock_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM read/write port pair between two requesters.
// Muxes the granted access onto the SRAM and steers 1-cycle read data back to its owner.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int AW       = BUS_WIDTH,
  parameter int DW       = DATA_WIDTH,
  parameter int MAX_LOCK = SRAM_ARB_MAX_LOCK
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req0,
  input  logic            req1,
  input  logic            we0,
  input  logic            we1,
  input  logic [AW-1:0]   addr0,
  input  logic [AW-1:0]   addr1,
  input  logic [DW-1:0]   wdata0,
  input  logic [DW-1:0]   wdata1,
  input  logic [DW/8-1:0] wstrb0,
  input  logic [DW/8-1:0] wstrb1,
  input  logic            lock0,
  input  logic            lock1,
  output logic            gnt0,
  output logic            gnt1,
  output logic            rvalid0,
  output logic            rvalid1,
  output logic [DW-1:0]   rdata0,
  output logic [DW-1:0]   rdata1,
  output logic [AW-1:0]   ram_raddr,
  output logic            ram_ren,
  output logic [AW-1:0]   ram_waddr,
  output logic [DW-1:0]   ram_wdata,
  output logic [DW/8-1:0] ram_wen,
  input  logic [DW-1:0]   ram_rdata
);

  logic [1:0]      gnt;
  logic            sel;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic [DW/8-1:0] sel_wstrb;
  logic            rd_go;
  logic            wr_go;
  logic            rd_pend;
  port_e           rd_owner;
  logic [AW-1:0]   raddr_hold;
  logic [AW-1:0]   waddr_hold;
  logic [DW-1:0]   wdata_hold;

  rr_arb2 #(.MAX_LOCK(MAX_LOCK)) u_arb (
    .clk    (clk),
    .resetn (resetn),
    .req    ({req1, req0}),
    .lock   ({lock1, lock0}),
    .gnt    (gnt)
  );

  assign gnt0      = gnt[0];
  assign gnt1      = gnt[1];
  assign sel       = gnt[1];
  assign sel_we    = sel ? we1 : we0;
  assign sel_addr  = sel ? addr1 : addr0;
  assign sel_wdata = sel ? wdata1 : wdata0;
  assign sel_wstrb = sel ? wstrb1 : wstrb0;
  assign rd_go     = (|gnt) && !sel_we;
  assign wr_go     = (|gnt) && sel_we;

  // idle cycles keep the last address/data on the SRAM pins
  assign ram_ren   = rd_go;
  assign ram_raddr = rd_go ? sel_addr : raddr_hold;
  assign ram_wen   = wr_go ? sel_wstrb : {(DW/8){1'b0}};
  assign ram_waddr = wr_go ? sel_addr : waddr_hold;
  assign ram_wdata = wr_go ? sel_wdata : wdata_hold;

  // read-return tracking and SRAM pin hold registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_pend    <= 1'b0;
      rd_owner   <= PORT0;
      raddr_hold <= {AW{1'b0}};
      waddr_hold <= {AW{1'b0}};
      wdata_hold <= {DW{1'b0}};
    end else begin
      rd_pend <= rd_go;
      if (rd_go) begin
        rd_owner   <= port_e'(sel);
        raddr_hold <= sel_addr;
      end else begin
        rd_owner   <= rd_owner;
        raddr_hold <= raddr_hold;
      end
      if (wr_go) begin
        waddr_hold <= sel_addr;
        wdata_hold <= sel_wdata;
      end else begin
        waddr_hold <= waddr_hold;
        wdata_hold <= wdata_hold;
      end
    end
  end

  assign rvalid0 = rd_pend && (rd_owner == PORT0);
  assign rvalid1 = rd_pend && (rd_owner == PORT1);
  assign rdata0  = rvalid0 ? ram_rdata : {DW{1'b0}};
  assign rdata1  = rvalid1 ? ram_rdata : {DW{1'b0}};

endmodule
